// File: rtl/debounce_sync_if.sv
// Signal bundle between a bouncy input source and the debounce stage.
// master: the side that owns the raw input and consumes the conditioned
// level and edge pulses. slave: the debounce stage itself.
// dbg_state mirrors the debounce FSM state register for observation only.
interface debounce_sync_if;
    logic       async_i;
    logic       level_o;
    logic       rise_o;
    logic       fall_o;
    logic       busy_o;
    logic [1:0] dbg_state;

    modport master (
        output async_i,
        input  level_o,
        input  rise_o,
        input  fall_o,
        input  busy_o,
        input  dbg_state
    );

    modport slave (
        input  async_i,
        output level_o,
        output rise_o,
        output fall_o,
        output busy_o,
        output dbg_state
    );
endinterface

// File: rtl/debounce_sync.sv
// Input conditioning for a raw button/switch signal.
// The raw input passes through a plain flop synchroniser chain, then a
// four-state counter-qualified FSM. A change is accepted only after the
// synchronised value has differed from the current level for
// DEBOUNCE_CYCLES+1 consecutive samples. Any shorter excursion is dropped.
// On acceptance level_o switches and a single-cycle rise_o or fall_o pulse
// is issued in the same cycle as the new level.
// Steady-input latency: if async_i is first sampled at edge E0, level_o
// and the pulse appear after edge E0 + SYNC_STAGES + DEBOUNCE_CYCLES.
// Every output comes straight from a register, or from a decode of
// registers only, so async_i has no combinational path to any output.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    debounce_sync_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syn;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    // Synchroniser shift chain; nothing sits between stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.async_i};
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

    // Debounce FSM: qualify each candidate change with a run counter.
    // cnt counts consecutive differing samples already seen in a CHK state,
    // so it only ever ranges 0..DEBOUNCE_CYCLES and cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_LOW;
            cnt     <= CNT_ZERO;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                ST_LOW: begin
                    level_q <= 1'b0;
                    if (syn) begin
                        state <= ST_CHK_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_CHK_HIGH: begin
                    if (!syn) begin
                        // Excursion too short: back to LOW, no pulse.
                        state <= ST_LOW;
                        cnt   <= CNT_ZERO;
                    end else if (cnt == CNT_MAX) begin
                        state   <= ST_HIGH;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                        cnt     <= CNT_ZERO;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    level_q <= 1'b1;
                    if (!syn) begin
                        state <= ST_CHK_LOW;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_CHK_LOW: begin
                    if (syn) begin
                        // Excursion too short: back to HIGH, no pulse.
                        state <= ST_HIGH;
                        cnt   <= CNT_ZERO;
                    end else if (cnt == CNT_MAX) begin
                        state   <= ST_LOW;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                        cnt     <= CNT_ZERO;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= ST_LOW;
                    cnt     <= CNT_ZERO;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    // busy is a pure decode of the state register.
    assign bus.busy_o    = (state == ST_CHK_HIGH) || (state == ST_CHK_LOW);
    assign bus.level_o   = level_q;
    assign bus.rise_o    = rise_q;
    assign bus.fall_o    = fall_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync. Two instances share one stimulus stream:
// dut_a uses the default parameters (SYNC_STAGES=2, DEBOUNCE_CYCLES=4),
// dut_b uses SYNC_STAGES=3, DEBOUNCE_CYCLES=1.
// The reference model delays the raw input by the synchroniser depth and
// accepts a new level once it has been seen DEBOUNCE_CYCLES+1 samples in a
// row; a fixed set of literal checks pins the exact latencies.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst_n;
    logic async_in;

    int checks = 0;
    int errors = 0;

    debounce_sync_if bus_a ();
    debounce_sync_if bus_b ();

    assign bus_a.async_i = async_in;
    assign bus_b.async_i = async_in;

    debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model + expected queues ----------------
    // Expected vector layout: {level, rise, fall, busy}
    logic [3:0] exp_q_a[$];
    logic [3:0] exp_q_b[$];

    int s_p[2] = '{2, 3};
    int d_p[2] = '{4, 1};
    int hist[2][8];
    int m_level[2];
    int m_run[2];
    int m_rise[2];
    int m_fall[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) hist[k][j] = 0;
            m_level[k] = 0;
            m_run[k]   = 0;
            m_rise[k]  = 0;
            m_fall[k]  = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                int seen;
                logic [3:0] ev;
                if (!rst_n) begin
                    for (int j = 0; j < 8; j++) hist[k][j] = 0;
                    m_level[k] = 0;
                    m_run[k]   = 0;
                    m_rise[k]  = 0;
                    m_fall[k]  = 0;
                end else begin
                    // value the debouncer sees this edge: raw input from
                    // s_p[k] edges ago
                    seen = hist[k][s_p[k]-1];
                    for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
                    hist[k][0] = (async_in === 1'b1) ? 1 : 0;
                    m_rise[k] = 0;
                    m_fall[k] = 0;
                    if (seen != m_level[k]) begin
                        m_run[k] = m_run[k] + 1;
                        if (m_run[k] == d_p[k] + 1) begin
                            m_level[k] = seen;
                            m_rise[k]  = seen;
                            m_fall[k]  = 1 - seen;
                            m_run[k]   = 0;
                        end
                    end else begin
                        m_run[k] = 0;
                    end
                end
                ev = {m_level[k] != 0, m_rise[k] != 0, m_fall[k] != 0, m_run[k] != 0};
                if (k == 0) exp_q_a.push_back(ev);
                else        exp_q_b.push_back(ev);
            end
        end
    end

    // ---------------- scoreboard compare, every cycle ----------------
    initial begin
        forever begin
            logic [3:0] ev;
            logic [3:0] av;
            @(negedge clk);
            if (exp_q_a.size() > 0) begin
                ev = exp_q_a.pop_front();
                av = {bus_a.level_o, bus_a.rise_o, bus_a.fall_o, bus_a.busy_o};
                checks++;
                if (av !== ev) begin
                    errors++;
                    $display("FAIL model_a t=%0t {level,rise,fall,busy} got=%b exp=%b", $time, av, ev);
                end
            end
            if (exp_q_b.size() > 0) begin
                ev = exp_q_b.pop_front();
                av = {bus_b.level_o, bus_b.rise_o, bus_b.fall_o, bus_b.busy_o};
                checks++;
                if (av !== ev) begin
                    errors++;
                    $display("FAIL model_b t=%0t {level,rise,fall,busy} got=%b exp=%b", $time, av, ev);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, act, exp);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        async_in = 1'b0;
        step(3);
        check_bit("rst_level_a", bus_a.level_o, 1'b0);
        check_bit("rst_rise_a",  bus_a.rise_o,  1'b0);
        check_bit("rst_fall_a",  bus_a.fall_o,  1'b0);
        check_bit("rst_busy_a",  bus_a.busy_o,  1'b0);
        check_bit("rst_level_b", bus_b.level_o, 1'b0);
        rst_n = 1'b1;
        step(3);

        // One-sample glitch: dut_b (single check cycle) must still reject it
        async_in = 1'b1;
        step(1);
        async_in = 1'b0;
        step(8);
        check_bit("glitch_level_b", bus_b.level_o, 1'b0);
        check_bit("glitch_level_a", bus_a.level_o, 1'b0);

        // Steady rise; next posedge is E0
        async_in = 1'b1;
        step(4);  // after E0+3
        check_bit("rise_b_early", bus_b.level_o, 1'b0);
        step(1);  // after E0+4
        check_bit("rise_b_level", bus_b.level_o, 1'b1);
        check_bit("rise_b_pulse", bus_b.rise_o,  1'b1);
        check_bit("rise_a_early4", bus_a.level_o, 1'b0);
        step(1);  // after E0+5
        check_bit("rise_a_early5", bus_a.level_o, 1'b0);
        check_bit("rise_b_clear", bus_b.rise_o,  1'b0);
        step(1);  // after E0+6
        check_bit("rise_a_level", bus_a.level_o, 1'b1);
        check_bit("rise_a_pulse", bus_a.rise_o,  1'b1);
        step(1);  // after E0+7
        check_bit("rise_a_clear", bus_a.rise_o,  1'b0);
        check_bit("rise_a_hold",  bus_a.level_o, 1'b1);
        step(4);

        // Steady fall from HIGH, same latency
        async_in = 1'b0;
        step(6);  // after E0+5
        check_bit("fall_a_early", bus_a.level_o, 1'b1);
        check_bit("fall_a_nopulse", bus_a.fall_o, 1'b0);
        step(1);  // after E0+6
        check_bit("fall_a_level", bus_a.level_o, 1'b0);
        check_bit("fall_a_pulse", bus_a.fall_o,  1'b1);
        step(1);
        check_bit("fall_a_clear", bus_a.fall_o,  1'b0);
        step(4);

        // Three-cycle excursion from LOW: busy shows, level holds
        async_in = 1'b1;
        step(3);  // after E0+2
        async_in = 1'b0;
        check_bit("short_busy_a", bus_a.busy_o, 1'b1);
        step(1);
        check_bit("short_busy_a2", bus_a.busy_o, 1'b1);
        step(10);
        check_bit("short_level_a", bus_a.level_o, 1'b0);
        check_bit("short_idle_a",  bus_a.busy_o,  1'b0);

        // Toggle every 2 cycles for 40 cycles
        for (int i = 0; i < 20; i++) begin
            async_in = ~async_in;
            step(2);
        end
        async_in = 1'b0;
        step(10);
        check_bit("toggle_level_a", bus_a.level_o, 1'b0);

        // Reset during CHK_HIGH with cnt=3 (after E0+4)
        async_in = 1'b1;
        step(5);
        check_bit("mid_busy_a",  bus_a.busy_o,  1'b1);
        check_bit("mid_level_a", bus_a.level_o, 1'b0);
        rst_n = 1'b0;
        step(1);
        check_bit("abort_level_a", bus_a.level_o, 1'b0);
        check_bit("abort_rise_a",  bus_a.rise_o,  1'b0);
        check_bit("abort_busy_a",  bus_a.busy_o,  1'b0);
        check_bit("abort_level_b", bus_b.level_o, 1'b0);
        check_bit("abort_rise_b",  bus_b.rise_o,  1'b0);
        rst_n = 1'b1;  // async_in still high; next posedge is R0
        step(6);       // after R0+5
        check_bit("rel_a_early", bus_a.level_o, 1'b0);
        step(1);       // after R0+6
        check_bit("rel_a_level", bus_a.level_o, 1'b1);
        check_bit("rel_a_pulse", bus_a.rise_o,  1'b1);
        step(3);

        // Random runs of random length, with occasional resets
        for (int i = 0; i < 600; i++) begin
            int len;
            len = $urandom_range(1, 8);
            async_in = $urandom_range(0, 1) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step(len);
        end

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
